bound_flasher_core: RTL

BOUND_FLASHER_CORE -- requirements
Module: bound_flasher_core

---
 rtl/bound_flasher_core.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bound_flasher_core.sv
// rtl/bound_flasher_core.sv - bounded LED flasher sequencer with kickback and done pulse
module bound_flasher_core #(
  parameter int N_LED = 16,
  parameter int B1    = 5,
  parameter int B2    = 10
) (
  input  logic             div_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             flick,
  output logic [N_LED-1:0] led,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(N_LED + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] UP_ALL    = 3'd1;
  localparam logic [2:0] DOWN_MID  = 3'd2;
  localparam logic [2:0] UP_MID    = 3'd3;
  localparam logic [2:0] DOWN_ZERO = 3'd4;
  localparam logic [2:0] UP_LOW    = 3'd5;
  localparam logic [2:0] DOWN_LOW  = 3'd6;

  localparam logic [CW-1:0] C_ZERO = '0;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_N    = CW'(N_LED);
  localparam logic [CW-1:0] C_NM1  = CW'(N_LED - 1);
  localparam logic [CW-1:0] C_B1   = CW'(B1);
  localparam logic [CW-1:0] C_B1P1 = CW'(B1 + 1);
  localparam logic [CW-1:0] C_B1M1 = CW'(B1 - 1);
  localparam logic [CW-1:0] C_B2   = CW'(B2);
  localparam logic [CW-1:0] C_B2M1 = CW'(B2 - 1);

  logic [CW-1:0] count, count_nx;
  logic [2:0]    state_nx;
  logic          done_nx;

  always_comb begin
    state_nx = state;
    count_nx = count;
    done_nx  = 1'b0;
    if (clr) begin
      state_nx = IDLE;
      count_nx = C_ZERO;
    end else if (en) begin
      case (state)
        IDLE: begin
          state_nx = flick ? UP_ALL : IDLE;
          count_nx = C_ZERO;
        end
        UP_ALL: begin
          if (count < C_N) count_nx = count + C_ONE;
          else begin
            state_nx = DOWN_MID;
            count_nx = C_NM1;
          end
        end
        // At B1 a held flick sends the pattern back up to full scale
        DOWN_MID: begin
          if (count > C_B1) count_nx = count - C_ONE;
          else begin
            state_nx = flick ? UP_ALL : UP_MID;
            count_nx = C_B1P1;
          end
        end
        UP_MID: begin
          if (count < C_B2) count_nx = count + C_ONE;
          else begin
            state_nx = DOWN_ZERO;
            count_nx = C_B2M1;
          end
        end
        DOWN_ZERO: begin
          if (flick && count == C_B1) begin
            state_nx = UP_MID;
            count_nx = C_B1P1;
          end else if (count == C_ZERO) begin
            state_nx = flick ? UP_MID : UP_LOW;
            count_nx = C_ONE;
          end else begin
            count_nx = count - C_ONE;
          end
        end
        UP_LOW: begin
          if (count < C_B1) count_nx = count + C_ONE;
          else begin
            state_nx = DOWN_LOW;
            count_nx = C_B1M1;
          end
        end
        DOWN_LOW: begin
          if (count != C_ZERO) count_nx = count - C_ONE;
          else begin
            state_nx = IDLE;
            count_nx = C_ZERO;
            done_nx  = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = C_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= C_ZERO;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      done  <= done_nx;
    end
  end

  // Thermometer decode: LED i lights while the count is above i
  for (genvar i = 0; i < N_LED; i++) begin : g_led
    assign led[i] = (count > CW'(i));
  end

  assign busy = (state != IDLE);

endmodule
